// File: rtl/drive_cmd_pkg.sv
// Shared types and constants for the drive command path: parser/motor state
// encodings, frame header bytes, direction encoding and setpoint limits.
package drive_cmd_pkg;

  typedef enum logic [2:0] {P_A, P_B, P_C, P_S1, P_S0, P_T1, P_T0, P_CK} parserStateT;
  typedef enum logic [1:0] {M_SAFE, M_RUN, M_DEAD} motorStateT;
  typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dirT;

  localparam logic [7:0]  HDR_A      = 8'h61;  // 'a'
  localparam logic [7:0]  HDR_B      = 8'h62;  // 'b'
  localparam logic [7:0]  HDR_C      = 8'h63;  // 'c'
  localparam logic [15:0] THR_CENTER = 16'd512;
  localparam logic [15:0] THR_MAX    = 16'd1023;
  localparam logic [15:0] STEER_MAX  = 16'd1000;
  localparam logic [15:0] SERVO_MIN  = 16'd1000;

  function automatic logic [15:0] clampU16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/drive_frame_parser.sv
// Byte-level parser for 8-byte drive frames: header match, inter-byte timeout
// and XOR checksum. Emits one-cycle frame_ok/frame_err pulses.
module drive_frame_parser
  import drive_cmd_pkg::*;
#(
  parameter int unsigned BYTE_TO_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] steer,
  output logic [15:0] thr
);

  localparam int TW = (BYTE_TO_CYC > 1) ? $clog2(BYTE_TO_CYC) : 1;

  parserStateT   stateReg, stateNext;
  logic [TW-1:0] timerReg;
  logic [7:0]    sHi, sLo, tHi, tLo;
  logic          timeout, ckMatch, ckByte;

  // The timer idles in P_A so a silent line never produces an error.
  assign timeout = (stateReg != P_A) && !rx_valid && (timerReg == TW'(BYTE_TO_CYC - 1));
  assign ckMatch = (rx_data == (sHi ^ sLo ^ tHi ^ tLo));
  assign ckByte  = rx_valid && (stateReg == P_CK);

  always_comb begin
    stateNext = stateReg;
    if (timeout) begin
      stateNext = P_A;
    end else if (rx_valid) begin
      case (stateReg)
        P_A:     stateNext = (rx_data == HDR_A) ? P_B : P_A;
        P_B:     stateNext = (rx_data == HDR_B) ? P_C : ((rx_data == HDR_A) ? P_B : P_A);
        P_C:     stateNext = (rx_data == HDR_C) ? P_S1 : ((rx_data == HDR_A) ? P_B : P_A);
        P_S1:    stateNext = P_S0;
        P_S0:    stateNext = P_T1;
        P_T1:    stateNext = P_T0;
        P_T0:    stateNext = P_CK;
        default: stateNext = P_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= P_A;
      timerReg  <= '0;
      sHi       <= '0;
      sLo       <= '0;
      tHi       <= '0;
      tLo       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      steer     <= '0;
      thr       <= '0;
    end else begin
      stateReg  <= stateNext;
      frame_ok  <= ckByte && ckMatch;
      frame_err <= timeout || (ckByte && !ckMatch);
      if (rx_valid || timeout || stateReg == P_A) timerReg <= '0;
      else                                         timerReg <= timerReg + 1'b1;
      if (rx_valid) begin
        case (stateReg)
          P_S1:    sHi <= rx_data;
          P_S0:    sLo <= rx_data;
          P_T1:    tHi <= rx_data;
          P_T0:    tLo <= rx_data;
          default: ;
        endcase
      end
      if (ckByte && ckMatch) begin
        steer <= {sHi, sLo};
        thr   <= {tHi, tLo};
      end
    end
  end

endmodule

// File: rtl/drive_cmd_controller.sv
// Drive command sequencer: turns parsed frames into servo/motor setpoints,
// commits them at PWM boundaries, inserts reversal dead-time and a watchdog failsafe.
module drive_cmd_controller
  import drive_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BYTE_TO_CYC   = CLK_HZ / 500,
  parameter int unsigned WDOG_CYC      = CLK_HZ / 4,
  parameter int unsigned DEADTIME_CYC  = CLK_HZ / 1000,
  parameter logic [15:0] MOTOR_MAX     = 16'd5000,
  parameter logic [15:0] SERVO_NEUTRAL = 16'd1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        upd_strobe,
  output logic [15:0] servo_duty,
  output logic [15:0] motor_duty,
  output logic        motor_a,
  output logic        motor_b,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        failsafe
);

  localparam int WW = $clog2(WDOG_CYC + 1);
  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;

  logic          frameOk, frameErr, commit, pendValid, wdogTrip;
  logic [15:0]   steerRaw, thrRaw, thrC, servoCalc, magRaw, magCalc;
  logic [15:0]   servoReg, servoPend, magPend;
  logic [15:0]   dutyReg, dutyNext, tgtMagReg, tgtMagNext;
  dirT           dirCalc, dirPend, dirReg, dirNext, tgtDirReg, tgtDirNext;
  motorStateT    mStateReg, mStateNext;
  logic [WW-1:0] wdogCnt;
  logic [DW-1:0] deadCntReg, deadNext;

  drive_frame_parser #(.BYTE_TO_CYC(BYTE_TO_CYC)) uParser (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_ok  (frameOk),
    .frame_err (frameErr),
    .steer     (steerRaw),
    .thr       (thrRaw)
  );

  assign frame_ok  = frameOk;
  assign frame_err = frameErr;
  assign wdogTrip  = (wdogCnt == WW'(WDOG_CYC));
  assign commit    = upd_strobe && pendValid && !wdogTrip;

  // Centre throttle keeps the present direction so a stop never forces a reversal.
  always_comb begin
    thrC      = clampU16(thrRaw, THR_MAX);
    servoCalc = SERVO_MIN + clampU16(steerRaw, STEER_MAX);
    dirCalc   = dirReg;
    magRaw    = '0;
    if (thrC > THR_CENTER) begin
      dirCalc = DIR_FWD;
      magRaw  = (thrC - THR_CENTER) << 3;
    end else if (thrC < THR_CENTER) begin
      dirCalc = DIR_REV;
      magRaw  = (THR_CENTER - thrC) << 3;
    end
    magCalc = clampU16(magRaw, MOTOR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdogCnt   <= '0;
      servoReg  <= SERVO_NEUTRAL;
      servoPend <= SERVO_NEUTRAL;
      dirPend   <= DIR_FWD;
      magPend   <= '0;
      pendValid <= 1'b0;
    end else begin
      if (frameOk)        wdogCnt <= '0;
      else if (!wdogTrip) wdogCnt <= wdogCnt + 1'b1;
      if (wdogTrip)       servoReg <= SERVO_NEUTRAL;
      else if (commit)    servoReg <= servoPend;
      // A frame landing with a commit refills the slot after the old values are consumed.
      if (frameOk) begin
        servoPend <= servoCalc;
        dirPend   <= dirCalc;
        magPend   <= magCalc;
        pendValid <= 1'b1;
      end else if (wdogTrip || commit) begin
        pendValid <= 1'b0;
      end
    end
  end

  always_comb begin
    mStateNext = mStateReg;
    dutyNext   = dutyReg;
    dirNext    = dirReg;
    deadNext   = deadCntReg;
    tgtDirNext = tgtDirReg;
    tgtMagNext = tgtMagReg;
    if (wdogTrip) begin
      mStateNext = M_SAFE;
      dutyNext   = '0;
    end else begin
      case (mStateReg)
        M_SAFE: if (commit) begin
          mStateNext = M_RUN;
          dirNext    = dirPend;
          dutyNext   = magPend;
        end
        M_RUN: if (commit) begin
          if (dirPend == dirReg || magPend == '0 || dutyReg == '0) begin
            dirNext  = dirPend;
            dutyNext = magPend;
          end else begin
            mStateNext = M_DEAD;
            dutyNext   = '0;
            deadNext   = '0;
            tgtDirNext = dirPend;
            tgtMagNext = magPend;
          end
        end
        M_DEAD: begin
          if (commit) begin
            tgtDirNext = dirPend;
            tgtMagNext = magPend;
          end
          if (deadCntReg == DW'(DEADTIME_CYC - 1)) begin
            mStateNext = M_RUN;
            dirNext    = tgtDirNext;
            dutyNext   = tgtMagNext;
          end else begin
            deadNext = deadCntReg + 1'b1;
          end
        end
        default: mStateNext = M_SAFE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStateReg  <= M_SAFE;
      dutyReg    <= '0;
      dirReg     <= DIR_FWD;
      deadCntReg <= '0;
      tgtDirReg  <= DIR_FWD;
      tgtMagReg  <= '0;
    end else begin
      mStateReg  <= mStateNext;
      dutyReg    <= dutyNext;
      dirReg     <= dirNext;
      deadCntReg <= deadNext;
      tgtDirReg  <= tgtDirNext;
      tgtMagReg  <= tgtMagNext;
    end
  end

  // Bridge inputs are driven only in M_RUN, so A and B can never both be high.
  assign servo_duty = servoReg;
  assign motor_duty = dutyReg;
  assign motor_a    = (mStateReg == M_RUN) && (dirReg == DIR_FWD);
  assign motor_b    = (mStateReg == M_RUN) && (dirReg == DIR_REV);
  assign failsafe   = (mStateReg == M_SAFE);

endmodule

// File: tb/tb_drive_cmd_controller.sv
// Randomized scoreboard bench for drive_cmd_controller: a behavioural model predicts
// frame events and per-cycle output snapshots; two monitors compare them with the DUT.
module tb_drive_cmd_controller;

  localparam int BYTE_TO = 40;
  localparam int WDOG    = 3000;
  localparam int DEAD    = 25;
  localparam int MMAX    = 5000;
  localparam int NEUTRAL = 1500;

  logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, upd_strobe = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] servo_duty, motor_duty;
  logic        motor_a, motor_b, frame_ok, frame_err, failsafe;

  drive_cmd_controller #(
    .CLK_HZ(50_000_000), .BYTE_TO_CYC(BYTE_TO), .WDOG_CYC(WDOG), .DEADTIME_CYC(DEAD),
    .MOTOR_MAX(16'd5000), .SERVO_NEUTRAL(16'd1500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .upd_strobe(upd_strobe), .servo_duty(servo_duty), .motor_duty(motor_duty),
    .motor_a(motor_a), .motor_b(motor_b), .frame_ok(frame_ok), .frame_err(frame_err),
    .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0, nFails = 0;
  int lastOkCyc = 0;

  typedef struct { int cyc; int servo; int duty; bit a; bit b; bit fs; } snapT;
  snapT snapQ[$];
  bit   evtQ[$];  // 1: frame_ok expected, 0: frame_err expected

  // Reference model: committed outputs and the pending slot.
  bit mSafe = 1'b1, mDir = 1'b0, pValid = 1'b0, pDir = 1'b0;
  int mDuty = 0, mServo = NEUTRAL, pServo = NEUTRAL, pMag = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushSnap(input int c);
    snapT s;
    s = '{c, mServo, mSafe ? 0 : mDuty, !mSafe && !mDir, !mSafe && mDir, mSafe};
    snapQ.push_back(s);
  endtask

  task automatic modelReset();
    mSafe = 1'b1; mDir = 1'b0; mDuty = 0; mServo = NEUTRAL; pValid = 1'b0;
  endtask

  task automatic modelLatch(input int steer, input int thr);
    int t;
    t = (thr > 1023) ? 1023 : thr;
    pServo = 1000 + ((steer > 1000) ? 1000 : steer);
    if (t > 512)      begin pDir = 1'b0; pMag = (t - 512) * 8; end
    else if (t < 512) begin pDir = 1'b1; pMag = (512 - t) * 8; end
    else              begin pDir = mDir; pMag = 0; end
    if (pMag > MMAX) pMag = MMAX;
    pValid = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sendFrame(input int steer, input int thr, input bit bad);
    logic [7:0] b [8];
    logic [15:0] s16, t16;
    s16 = 16'(steer);
    t16 = 16'(thr);
    b[0] = 8'h61; b[1] = 8'h62; b[2] = 8'h63;
    b[3] = s16[15:8]; b[4] = s16[7:0]; b[5] = t16[15:8]; b[6] = t16[7:0];
    b[7] = b[3] ^ b[4] ^ b[5] ^ b[6] ^ (bad ? 8'h5A : 8'h00);
    evtQ.push_back(!bad);
    $display("cyc %0d: frame tx steer=%0d thr=%0d badck=%0b", cyc, steer, thr, bad);
    for (int i = 0; i < 8; i++) sendByte(b[i], (i == 7) ? 0 : int'($urandom_range(1, 4)));
  endtask

  // Issues one upd_strobe; queues the expected output timeline and returns its length.
  task automatic commit(output int settle);
    int   n;
    snapT s;
    n = cyc;
    settle = 1;
    upd_strobe = 1'b1;
    if (pValid) begin
      mServo = pServo;
      if (!mSafe && pDir != mDir && pMag != 0 && mDuty != 0) begin
        for (int k = 1; k <= DEAD; k++) begin
          s = '{n + k, mServo, 0, 1'b0, 1'b0, 1'b0};
          snapQ.push_back(s);
        end
        settle = DEAD + 1;
      end
      mSafe = 1'b0; mDir = pDir; mDuty = pMag; pValid = 1'b0;
    end
    pushSnap(n + settle);
    $display("cyc %0d: commit -> servo=%0d duty=%0d dir=%0d safe=%0b settle=%0d",
             n, mServo, mDuty, mDir, mSafe, settle);
    tick();
    upd_strobe = 1'b0;
  endtask

  // Frame event monitor.
  always @(negedge clk) begin
    if (rst_n && (frame_ok || frame_err)) begin
      nChecks++;
      if (evtQ.size() == 0) begin
        nFails++;
        $display("FAIL frame_evt cyc %0d: got ok=%0b err=%0b, required no event", cyc, frame_ok, frame_err);
      end else if (evtQ[0] ? (frame_ok !== 1'b1 || frame_err !== 1'b0)
                           : (frame_ok !== 1'b0 || frame_err !== 1'b1)) begin
        nFails++;
        $display("FAIL frame_evt cyc %0d: got ok=%0b err=%0b, required ok=%0b", cyc, frame_ok, frame_err, evtQ[0]);
        void'(evtQ.pop_front());
      end else begin
        $display("cyc %0d: frame event ok=%0b err=%0b", cyc, frame_ok, frame_err);
        void'(evtQ.pop_front());
      end
      if (frame_ok) lastOkCyc = cyc;
    end
  end

  // Output snapshot monitor plus bridge exclusivity.
  always @(negedge clk) begin
    snapT s;
    nChecks++;
    if (motor_a === 1'b1 && motor_b === 1'b1) begin
      nFails++;
      $display("FAIL ab_excl cyc %0d: got a=1 b=1, required not both high", cyc);
    end
    while (snapQ.size() > 0 && snapQ[0].cyc <= cyc) begin
      s = snapQ.pop_front();
      nChecks++;
      if (s.cyc != cyc || servo_duty !== 16'(s.servo) || motor_duty !== 16'(s.duty) ||
          motor_a !== s.a || motor_b !== s.b || failsafe !== s.fs) begin
        nFails++;
        $display("FAIL snap cyc %0d(exp %0d): got servo=%0d duty=%0d a=%0b b=%0b fs=%0b, required servo=%0d duty=%0d a=%0b b=%0b fs=%0b",
                 cyc, s.cyc, servo_duty, motor_duty, motor_a, motor_b, failsafe,
                 s.servo, s.duty, s.a, s.b, s.fs);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int settle, steer, thr;
    bit bad;
    repeat (3) tick();
    pushSnap(cyc);                     // reset state while rst_n held low
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    pushSnap(cyc);                     // idle, still neutral/failsafe
    sendByte(8'h78, BYTE_TO + 20);     // stray byte then silence: no error expected

    // Nominal frame then commit.
    sendFrame(500, 612, 1'b0); modelLatch(500, 612);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Corrupted checksum: outputs must stay put across two strobes.
    sendFrame(500, 612, 1'b1);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();
    commit(settle); repeat (settle + 2) tick();

    // Reversal under load: full dead-time.
    sendFrame(500, 412, 1'b0); modelLatch(500, 412);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Header resync on a repeated 'a', plus clamps on steer and throttle.
    sendByte(8'h61, 2);
    sendFrame(4000, 2000, 1'b0); modelLatch(4000, 2000);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Centre throttle stops without reversing, then reversal from zero is immediate.
    sendFrame(0, 512, 1'b0); modelLatch(0, 512);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();
    sendFrame(1000, 100, 1'b0); modelLatch(1000, 100);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Inter-byte timeout after a partial header, then a good frame.
    sendByte(8'h61, 2); sendByte(8'h62, 2); sendByte(8'h63, 0);
    evtQ.push_back(1'b0);
    repeat (BYTE_TO + 20) tick();
    sendFrame(250, 700, 1'b0); modelLatch(250, 700);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Frame and strobe in the same cycle: strobe commits the older frame.
    sendFrame(100, 900, 1'b0); modelLatch(100, 900);
    repeat (2) tick();
    sendFrame(800, 300, 1'b0);
    commit(settle); modelLatch(800, 300);
    repeat (settle + 2) tick();
    commit(settle); repeat (settle + 2) tick();

    // Randomized traffic.
    for (int it = 0; it < 14; it++) begin
      steer = int'($urandom_range(0, 1200));
      thr   = ($urandom_range(0, 7) == 0) ? 512 : int'($urandom_range(0, 1100));
      bad   = ($urandom_range(0, 3) == 0);
      sendFrame(steer, thr, bad);
      if (!bad) modelLatch(steer, thr);
      repeat (2) tick();
      if ($urandom_range(0, 3) != 0) begin
        commit(settle);
        repeat (settle + 2) tick();
      end
    end

    // Watchdog: last good frame, then silence with no strobes.
    sendFrame(600, 800, 1'b0); modelLatch(600, 800);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();
    while (cyc < lastOkCyc + WDOG - 5) tick();
    pushSnap(cyc);
    while (cyc < lastOkCyc + WDOG + 5) tick();
    mSafe = 1'b1; mServo = NEUTRAL; mDuty = 0; pValid = 1'b0;
    pushSnap(cyc);
    tick();
    sendFrame(300, 900, 1'b0); modelLatch(300, 900);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    // Asynchronous reset in the middle of a dead-time.
    sendFrame(300, 100, 1'b0); modelLatch(300, 100);
    repeat (2) tick(); commit(settle); repeat (10) tick();
    rst_n = 1'b0;
    snapQ.delete();
    modelReset();
    pushSnap(cyc);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    pushSnap(cyc);
    sendFrame(700, 400, 1'b0); modelLatch(700, 400);
    repeat (2) tick(); commit(settle); repeat (settle + 2) tick();

    repeat (10) tick();
    nChecks++;
    if (evtQ.size() != 0 || snapQ.size() != 0) begin
      nFails++;
      $display("FAIL leftover: got %0d frame events and %0d snapshots unchecked, required 0", evtQ.size(), snapQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
